// File: rtl/ctrl_step_sequencer.sv
// Control-step sequencer: fetch (T0..T2) plus the mfhi/mflo execute step (T3),
// with configurable memory-read latency, halt, sticky illegal-opcode flag and retire counter.
module ctrl_step_sequencer #(
   parameter int                    OPCODE_W = 5,
   parameter int                    MEM_LAT  = 1,
   parameter int                    CNT_W    = 16,
   parameter logic [OPCODE_W-1:0]   OP_MFHI  = OPCODE_W'(24),
   parameter logic [OPCODE_W-1:0]   OP_MFLO  = OPCODE_W'(25),
   parameter logic [OPCODE_W-1:0]   OP_NOP   = OPCODE_W'(26),
   parameter logic [OPCODE_W-1:0]   OP_HALT  = OPCODE_W'(27)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic [OPCODE_W-1:0] ir_opcode,
   output logic                PC_out,
   output logic                MAR_enable,
   output logic                Read,
   output logic                MDR_enable,
   output logic                MDR_out,
   output logic                IR_enable,
   output logic                PC_enable,
   output logic                IncPC,
   output logic                HI_out,
   output logic                LO_out,
   output logic                Gra,
   output logic                R_in,
   output logic [3:0]          step,
   output logic                busy,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0000,
      S_T0     = 4'b0111,
      S_T1     = 4'b1000,
      S_T2     = 4'b1001,
      S_T3     = 4'b1010,
      S_HALTED = 4'b1111
   } state_e;

   localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

   state_e             state_q, state_d;
   logic [3:0]         wait_q, wait_d;
   logic               illegal_q;
   logic [CNT_W-1:0]   retired_q;
   logic               pc_out_q, mar_en_q, read_q, mdr_en_q;
   logic               mdr_out_q, ir_en_q, pc_en_q, inc_pc_q;

   logic in_t3, is_mfhi, is_mflo, is_halt, known_op;

   assign in_t3    = (state_q == S_T3);
   assign is_mfhi  = (ir_opcode == OP_MFHI);
   assign is_mflo  = (ir_opcode == OP_MFLO);
   assign is_halt  = (ir_opcode == OP_HALT);
   assign known_op = is_mfhi || is_mflo || is_halt || (ir_opcode == OP_NOP);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_T0;
         S_T0: begin
            state_d = S_T1;
            wait_d  = WAIT_LOAD;
         end
         S_T1: begin
            if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
            else                state_d = S_T2;
         end
         S_T2:     state_d = S_T3;
         S_T3: begin
            if (is_halt)  state_d = S_HALTED;
            else if (run) state_d = S_T0;
            else          state_d = S_IDLE;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   // Fetch controls are registered from the next state so they line up with step.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         wait_q    <= 4'd0;
         illegal_q <= 1'b0;
         retired_q <= '0;
         pc_out_q  <= 1'b0;
         mar_en_q  <= 1'b0;
         read_q    <= 1'b0;
         mdr_en_q  <= 1'b0;
         mdr_out_q <= 1'b0;
         ir_en_q   <= 1'b0;
         pc_en_q   <= 1'b0;
         inc_pc_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         if (in_t3) begin
            retired_q <= retired_q + CNT_W'(1);
            if (!known_op) illegal_q <= 1'b1;
         end
         pc_out_q  <= (state_d == S_T0);
         mar_en_q  <= (state_d == S_T0);
         read_q    <= (state_d == S_T1);
         mdr_en_q  <= (state_d == S_T1);
         mdr_out_q <= (state_d == S_T2);
         ir_en_q   <= (state_d == S_T2);
         pc_en_q   <= (state_d == S_T2);
         inc_pc_q  <= (state_d == S_T2);
      end
   end

   assign PC_out     = pc_out_q;
   assign MAR_enable = mar_en_q;
   assign Read       = read_q;
   assign MDR_enable = mdr_en_q;
   assign MDR_out    = mdr_out_q;
   assign IR_enable  = ir_en_q;
   assign PC_enable  = pc_en_q;
   assign IncPC      = inc_pc_q;

   // Execute controls follow the opcode held in IR during T3.
   assign HI_out = in_t3 && is_mfhi;
   assign LO_out = in_t3 && is_mflo;
   assign Gra    = in_t3 && (is_mfhi || is_mflo);
   assign R_in   = in_t3 && (is_mfhi || is_mflo);

   assign step    = state_q;
   assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted  = (state_q == S_HALTED);
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule
